// File: rtl/icache_dm_if.sv
// Bundles the fetch-side and backing-memory-side signals of the direct-mapped
// instruction cache. The slave modport is the cache; master is the environment.
interface icache_dm_if #(
    parameter int ADDR_W = 32
);
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_instr;
    logic              cpu_ready;
    logic              invalidate;
    logic              mem_rd_req;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_rd_data;
    logic              mem_rd_valid;

    modport slave (
        input  cpu_req, cpu_addr, invalidate, mem_rd_data, mem_rd_valid,
        output cpu_instr, cpu_ready, mem_rd_req, mem_addr
    );

    modport master (
        output cpu_req, cpu_addr, invalidate, mem_rd_data, mem_rd_valid,
        input  cpu_instr, cpu_ready, mem_rd_req, mem_addr
    );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: zero-latency hits, sequential
// word-by-word line refill on a miss, and a one-cycle whole-cache flush.
module icache_dm #(
    parameter int LINES  = 16,
    parameter int WORDS  = 4,
    parameter int ADDR_W = 32
) (
    input  logic        clock,
    input  logic        reset,
    icache_dm_if.slave  bus
);
    localparam int OFF_W   = $clog2(WORDS);
    localparam int IDX_W   = $clog2(LINES);
    localparam int WADDR_W = ADDR_W - 2;
    localparam int LBASE_W = WADDR_W - OFF_W;
    localparam int TAG_W   = LBASE_W - IDX_W;

    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REFILL = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd2;

    logic [1:0]         r_state;
    logic [LINES-1:0]   r_valid;
    logic [TAG_W-1:0]   r_tags [LINES];
    logic [31:0]        r_data [LINES][WORDS];
    logic               r_pending;
    logic [OFF_W-1:0]   r_count;
    logic [LBASE_W-1:0] r_lineBase;

    logic [WADDR_W-1:0] w_wordAddr;
    logic [OFF_W-1:0]   w_offset;
    logic [IDX_W-1:0]   w_index;
    logic [TAG_W-1:0]   w_tag;
    logic [IDX_W-1:0]   w_fillIdx;
    logic [TAG_W-1:0]   w_fillTag;
    logic               w_hit;
    logic               w_lastWord;
    logic               w_flushReq;
    logic               w_refilling;
    logic               w_unused;

    assign w_wordAddr  = bus.cpu_addr[ADDR_W-1:2];
    assign w_offset    = w_wordAddr[OFF_W-1:0];
    assign w_index     = w_wordAddr[OFF_W +: IDX_W];
    assign w_tag       = w_wordAddr[WADDR_W-1 -: TAG_W];
    assign w_fillIdx   = r_lineBase[IDX_W-1:0];
    assign w_fillTag   = r_lineBase[LBASE_W-1 -: TAG_W];
    assign w_hit       = bus.cpu_req && r_valid[w_index] && (r_tags[w_index] == w_tag);
    assign w_lastWord  = (r_count == LAST_WORD);
    assign w_flushReq  = r_pending || bus.invalidate;
    assign w_refilling = (r_state == S_REFILL);
    assign w_unused    = &{1'b0, bus.cpu_addr[1:0]};

    // Hits are only served from IDLE; the instruction bus reads zero otherwise.
    assign bus.cpu_ready  = (r_state == S_IDLE) && w_hit;
    assign bus.cpu_instr  = bus.cpu_ready ? r_data[w_index][w_offset] : 32'h0;
    assign bus.mem_rd_req = w_refilling;
    assign bus.mem_addr   = w_refilling ? {r_lineBase, r_count} : '0;

    // A flush request outranks a miss in IDLE; a refill always runs to its last
    // word before a pending invalidate is honoured.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_valid   <= '0;
            r_pending <= 1'b0;
            r_count   <= '0;
        end else begin
            if (bus.invalidate) begin
                r_pending <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_flushReq) begin
                        r_state <= S_FLUSH;
                    end else if (bus.cpu_req && !w_hit) begin
                        r_lineBase <= w_wordAddr[WADDR_W-1:OFF_W];
                        r_count    <= '0;
                        r_state    <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (bus.mem_rd_valid) begin
                        r_count <= r_count + OFF_W'(1);
                        if (w_lastWord) begin
                            r_valid[w_fillIdx] <= 1'b1;
                            r_state            <= w_flushReq ? S_FLUSH : S_IDLE;
                        end
                    end
                end
                S_FLUSH: begin
                    r_valid   <= '0;
                    r_pending <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Storage arrays carry no reset; the valid bits alone decide what is usable.
    always_ff @(posedge clock) begin
        if (w_refilling && bus.mem_rd_valid) begin
            r_data[w_fillIdx][r_count] <= bus.mem_rd_data;
            if (w_lastWord) begin
                r_tags[w_fillIdx] <= w_fillTag;
            end
        end
    end
endmodule

// File: tb/tb_icache_dm.sv
// Randomized scoreboard bench for icache_dm against a line-level cache model
// and a wait-state-configurable backing memory.
module tb_icache_dm;
    localparam int LINES  = 16;
    localparam int WORDS  = 4;
    localparam int ADDR_W = 32;

    typedef struct {
        logic [31:0] instr;
        int          stall;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    icache_dm_if #(.ADDR_W(ADDR_W)) bus ();

    icache_dm #(.LINES(LINES), .WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   memWait = 0;
    int   waitCnt = 0;
    logic noise = 1'b0;
    exp_t expQ[$];
    exp_t monE;
    int   stallCnt = 0;
    int   wordIdx = 0;
    logic [29:0] expBase;

    logic        modelValid [LINES];
    logic [31:0] modelLine  [LINES];

    function automatic logic [31:0] memWord(input logic [29:0] a);
        return 32'h2008_0001 + {2'b00, a} + ({4'b0000, a[29:2]} << 12);
    endfunction

    // Memory answers after memWait idle cycles per word; valid is noise when not requested.
    assign bus.mem_rd_valid = bus.mem_rd_req ? (waitCnt >= memWait) : noise;
    assign bus.mem_rd_data  = memWord(bus.mem_addr);

    always @(posedge clock) begin
        if (bus.mem_rd_req && !bus.mem_rd_valid) waitCnt <= waitCnt + 1;
        else                                     waitCnt <= 0;
        noise <= 1'($urandom_range(0, 1));
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic finishSim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    // Scoreboard monitor: stall cycles and the instruction are judged when cpu_ready rises.
    always @(negedge clock) begin
        if (reset || !bus.cpu_req) begin
            stallCnt = 0;
        end else if (!bus.cpu_ready) begin
            stallCnt++;
        end else begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedReady: got ready=1, expected no pending fetch at %0t", $time);
            end else begin
                monE = expQ.pop_front();
                checkOutput("instr", bus.cpu_instr, monE.instr);
                checkOutput("stallCycles", 32'(stallCnt), 32'(monE.stall));
                checkOutput("memIdleOnHit", 32'(bus.mem_rd_req), 32'd0);
            end
            stallCnt = 0;
        end
    end

    // Refill words must walk the line of the held PC from word 0 with no skip or repeat.
    always @(negedge clock) begin
        if (reset || !bus.mem_rd_req) begin
            wordIdx = 0;
        end else begin
            expBase = bus.cpu_addr[31:2] & ~30'(WORDS - 1);
            checkOutput("memAddr", 32'(bus.mem_addr), 32'(expBase + 30'(wordIdx)));
            if (bus.mem_rd_valid) wordIdx++;
        end
    end

    task automatic clearModel();
        for (int i = 0; i < LINES; i++) modelValid[i] = 1'b0;
    endtask

    // invAt: -1 none, -2 random choice, otherwise the fetch cycle that carries the pulse.
    task automatic applyStimulus(input logic [31:0] addr, input int invAtIn);
        int    slot;
        int    refillLen;
        int    invAt;
        int    cyc;
        bit    hit;
        logic [31:0] lineAddr;
        exp_t  e;
        lineAddr  = addr / (WORDS * 4);
        slot      = int'(lineAddr % LINES);
        hit       = modelValid[slot] && (modelLine[slot] == lineAddr);
        refillLen = WORDS * (memWait + 1);
        invAt     = invAtIn;
        if (invAt == -2) begin
            if ($urandom_range(0, 7) == 0) invAt = hit ? 0 : int'($urandom_range(1, refillLen));
            else                           invAt = -1;
        end
        e.instr = memWord(addr[31:2]);
        if (hit)            e.stall = 0;
        else if (invAt > 0) e.stall = 2 * refillLen + 3;
        else                e.stall = refillLen + 1;
        expQ.push_back(e);
        if (invAt >= 0) clearModel();
        if (!(hit && invAt >= 0)) begin
            modelValid[slot] = 1'b1;
            modelLine[slot]  = lineAddr;
        end

        bus.cpu_req    = 1'b1;
        bus.cpu_addr   = addr;
        bus.invalidate = (invAt == 0);
        cyc = 0;
        forever begin
            @(negedge clock);
            if (bus.cpu_ready) break;
            cyc++;
            if (cyc > 400) begin
                checks++;
                errors++;
                $display("[TB] FAIL fetchTimeout: got no ready after %0d cycles, expected ready for 0x%08h", cyc, addr);
                finishSim();
            end
            @(posedge clock);
            #1;
            bus.invalidate = (cyc == invAt);
        end
        @(posedge clock);
        #1;
        bus.invalidate = 1'b0;
        if (hit && invAt >= 0) begin
            bus.cpu_req = 1'b0;
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        #500000;
        checks++;
        errors++;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        finishSim();
    end

    initial begin
        logic [31:0] addr;
        reset          = 1'b1;
        bus.cpu_req    = 1'b0;
        bus.cpu_addr   = '0;
        bus.invalidate = 1'b0;
        clearModel();
        for (int i = 0; i < LINES; i++) modelLine[i] = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("rstReady", 32'(bus.cpu_ready), 32'd0);
        checkOutput("rstInstr", bus.cpu_instr, 32'd0);
        checkOutput("rstMemReq", 32'(bus.mem_rd_req), 32'd0);
        checkOutput("rstMemAddr", 32'(bus.mem_addr), 32'd0);
        @(posedge clock);
        #1;

        $display("[TB] cold miss and sequential hits");
        memWait = 0;
        applyStimulus(32'h0000_0000, -1);
        applyStimulus(32'h0000_0004, -1);
        applyStimulus(32'h0000_0008, -1);
        applyStimulus(32'h0000_000C, -1);

        $display("[TB] conflict miss on index 0");
        applyStimulus(32'h0000_0100, -1);
        applyStimulus(32'h0000_0000, -1);

        $display("[TB] three wait states per word");
        memWait = 3;
        applyStimulus(32'h0000_0230, -1);
        applyStimulus(32'h0000_0234, -1);

        $display("[TB] invalidate during refill and during a hit");
        memWait = 1;
        applyStimulus(32'h0000_0540, 3);
        applyStimulus(32'h0000_0000, -1);
        applyStimulus(32'h0000_0540, 0);
        applyStimulus(32'h0000_0544, -1);

        $display("[TB] reset in second refill cycle");
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 32'h0000_0780;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset       = 1'b1;
        bus.cpu_req = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        clearModel();
        @(negedge clock);
        checkOutput("midRstReady", 32'(bus.cpu_ready), 32'd0);
        checkOutput("midRstInstr", bus.cpu_instr, 32'd0);
        checkOutput("midRstMemReq", 32'(bus.mem_rd_req), 32'd0);
        checkOutput("midRstMemAddr", 32'(bus.mem_addr), 32'd0);
        @(posedge clock);
        #1;
        applyStimulus(32'h0000_0780, -1);

        $display("[TB] randomized fetches");
        for (int n = 0; n < 80; n++) begin
            memWait = int'($urandom_range(0, 2));
            addr = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 15)) << 4)
                 | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            applyStimulus(addr, -2);
        end

        bus.cpu_req = 1'b0;
        repeat (3) @(posedge clock);
        checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
        finishSim();
    end
endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the pipeline's IF stage (PC, IFID register) and a multi-cycle backing instruction memory.
- Hits return the instruction in the same cycle.
- Misses stall fetch via cpu_ready=0 while a line refill runs word by word over a valid/request handshake.
- Provides a whole-cache invalidate for self-modifying code or a program reload.

Parameters:
- LINES, 16, number of cache lines (power of 2, at least 2).
- WORDS, 4, 32-bit words per line (power of 2, at least 2).
- ADDR_W, 32, CPU byte-address width.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  fetch request valid.
- cpu_addr  in  ADDR_W  fetch byte address (PC); bits [1:0] ignored.
- cpu_instr  out  32  fetched instruction; valid when cpu_req && cpu_ready.
- cpu_ready  out  1  1 = cpu_instr valid this cycle; 0 = stall (the pipeline holds PC and IFID).
- invalidate  in  1  single-cycle pulse requesting that all lines be invalidated.
- mem_rd_req  out  1  backing-memory read request.
- mem_addr  out  ADDR_W-2  backing-memory word address.
- mem_rd_data  in  32  backing-memory read data.
- mem_rd_valid  in  1  mem_rd_data valid; completes the current request.

Behaviour:
- Address split on the word address (cpu_addr>>2):
  - offset = low log2(WORDS) bits.
  - index = next log2(LINES) bits.
  - tag = remaining upper bits.
  - Defaults: offset [3:2], index [7:4], tag [31:8].
- Storage: data array LINES×WORDS×32, tag array, and a per-line valid bit. Only valid bits are reset.
- FSM states: IDLE, REFILL, FLUSH.
- IDLE:
  - hit = cpu_req && valid[index] && tag match.
  - On a hit: cpu_ready=1, cpu_instr = data[index][offset] (combinational, zero latency).
  - On cpu_req && miss: cpu_ready=0; latch the line base word address {tag,index,0}; clear the word counter; go to REFILL.
  - With cpu_req=0: cpu_ready=0 and cpu_instr=0.
- REFILL:
  - mem_rd_req=1 and mem_addr = line base + counter; both held stable until mem_rd_valid=1.
  - On each mem_rd_valid: write mem_rd_data to data[index][counter] and increment the counter.
  - After word WORDS-1 is written: write the tag, set valid[index]=1, return to IDLE.
  - The hit is then served the following cycle. Minimum miss penalty is WORDS+1 cycles with zero-wait memory.
  - cpu_ready=0 throughout REFILL.
  - The refill always completes, even if cpu_req drops or cpu_addr changes. The pipeline holds cpu_addr stable while stalled.
  - Fill order is sequential from word 0; there is no critical-word-first.
- mem_rd_valid is ignored whenever mem_rd_req=0.
- Invalidate:
  - An invalidate pulse sets a pending flag, held until serviced.
  - If the pulse arrives in IDLE, the FSM goes to FLUSH on the next edge; the hit in that cycle is still served.
  - If the pulse arrives during REFILL, the refill finishes, then the FSM goes to FLUSH instead of IDLE.
  - FLUSH lasts one cycle: clear all valid bits, clear the pending flag, cpu_ready=0, return to IDLE.
  - An invalidate pulse arriving during FLUSH is absorbed by that flush.
- Reset, including mid-refill: the FSM returns to IDLE, all valid bits clear, pending flag clears, counter clears.
  - Output reset values: cpu_ready=0, cpu_instr=0, mem_rd_req=0, mem_addr=0.
  - Partial line data is discarded, because the line remains invalid.
- Wrap-around: the word counter is log2(WORDS) bits. It is compared at WORDS-1 and never wraps into a second refill.

Test Plan:
- Reset, then cpu_req=1 with cpu_addr=0x0000_0000, memory returning 0x20080001..4 with zero wait:
  - mem_addr steps 0,1,2,3;
  - cpu_ready=0 for 5 cycles, then cpu_ready=1 with cpu_instr=0x20080001.
- After the line fill, fetch 0x4, 0x8, 0xC on consecutive cycles: cpu_ready=1 every cycle, instructions 0x20080002..4, mem_rd_req stays 0.
- Conflict miss at 0x0000_0100 (same index 0, tag 1):
  - a new refill runs at mem_addr 0x40..0x43;
  - a later fetch of 0x0 misses again.
- Memory with 3-cycle wait per word: mem_addr is held stable until each mem_rd_valid; total stall is 4×4+1 cycles; no word is skipped or duplicated.
- invalidate pulsed mid-refill: the refill completes, a FLUSH cycle follows (cpu_ready=0), and refetching that same address misses.
- reset asserted in the 2nd cycle of a refill: outputs return to 0; refetching the same address issues a fresh refill starting at word 0.
